// File: rtl/vlc_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlc_frame_pkg
// Description : Shared definitions for the receive-side frame checker:
//               the default frame length, the checker states, the test pattern
//               word and the eof byte-compare mask.
// Revision    : 1.0 - initial release
// ============================================================================
package vlc_frame_pkg;

    localparam logic [15:0] FRAME_LEN_DEF = 16'd200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FRAME = 2'd1,
        ST_DROP     = 2'd2
    } frame_state_e;

    // Word k of frame s carries the sequence number high and the index low.
    function automatic logic [31:0] pattern_word(input logic [15:0] seq,
                                                 input logic [15:0] idx);
        return {seq, idx};
    endfunction

    // On the eof word the low 'be' bytes are empty and must not be compared.
    function automatic logic [31:0] cmp_mask(input logic eof, input logic [1:0] be);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF;
        if (eof) begin
            mask = mask << {be, 3'b000};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cnt32.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt32
// Description : 32-bit counter that adds a variable amount per enabled cycle,
//               saturates at all-ones and has a synchronous clear that wins
//               over a same-cycle increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        inc_en_i,
    input  logic [31:0] inc_amt_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [32:0] sum_full;

    // Next count: clear first, otherwise add with saturation on carry-out.
    always_comb begin
        sum_full = {1'b0, cnt_q} + {1'b0, inc_amt_i};
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_en_i) begin
            cnt_d = sum_full[32] ? 32'hFFFF_FFFF : sum_full[31:0];
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_checker
// Description : Terminal consumer of the receive frame stream. Checks every
//               frame against the transmit test pattern (content, length and
//               sequence), keeps saturating statistics, a sticky error flag
//               and drives a stallable ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_checker
    import vlc_frame_pkg::*;
#(
    parameter logic [15:0] FRAME_LEN_VAL = FRAME_LEN_DEF,
    parameter logic        SEQ_CHECK_EN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_stall,
    input  logic        i_ps_val,
    input  logic        i_ps_sof,
    input  logic        i_ps_eof,
    input  logic [1:0]  i_ps_be,
    input  logic [31:0] i_ps_data,
    output logic        o_ps_rdy,
    output logic [31:0] o_good_frame_num,
    output logic [31:0] o_bad_frame_num,
    output logic [31:0] o_lost_frame_num,
    output logic [31:0] o_err_word_num,
    output logic        o_err_sticky,
    output logic        o_frame_done
);

    frame_state_e state_q, state_d;
    logic [15:0]  idx_q, idx_d;
    logic [15:0]  seq_q, seq_d;
    logic [15:0]  exp_seq_q, exp_seq_d;
    logic         seeded_q, seeded_d;
    logic         frame_bad_q, frame_bad_d;
    logic         rdy_q;
    logic         done_q, done_d;
    logic         sticky_q, sticky_d;

    logic         xfer;
    logic [15:0]  new_seq;
    logic [15:0]  gap;
    logic [31:0]  exp_word;
    logic         word_err;
    logic [15:0]  word_cnt;
    logic         bad_now;
    logic         track;
    logic         good_inc;
    logic [1:0]   bad_inc;
    logic         err_inc;
    logic [31:0]  lost_amt;

    assign xfer     = i_ps_val & rdy_q;
    assign new_seq  = i_ps_data[31:16];
    assign gap      = new_seq - exp_seq_q;
    // A sof word is always word 0 of the sequence number it carries.
    assign exp_word = i_ps_sof ? pattern_word(new_seq, 16'd0) : pattern_word(seq_q, idx_q);
    assign word_err = |((i_ps_data ^ exp_word) & cmp_mask(i_ps_eof, i_ps_be));

    // Frame tracking: open on sof, compare while in frame, close on eof,
    // premature sof or length overflow.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        exp_seq_d   = exp_seq_q;
        seeded_d    = seeded_q;
        frame_bad_d = frame_bad_q;
        good_inc    = 1'b0;
        bad_inc     = 2'd0;
        err_inc     = 1'b0;
        lost_amt    = '0;
        word_cnt    = idx_q + 16'd1;
        bad_now     = frame_bad_q | word_err;
        track       = 1'b0;

        if (xfer) begin
            if (i_ps_sof) begin
                // A frame still open here never saw its eof.
                if (state_q == ST_IN_FRAME) begin
                    bad_inc = 2'd1;
                end
                if (SEQ_CHECK_EN && seeded_q && (gap != 16'd0)) begin
                    lost_amt = {16'd0, gap};
                end
                seq_d     = new_seq;
                exp_seq_d = new_seq + 16'd1;
                seeded_d  = 1'b1;
                word_cnt  = 16'd1;
                bad_now   = word_err;
                track     = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE:     err_inc = 1'b1;
                    ST_IN_FRAME: track   = 1'b1;
                    ST_DROP: begin
                        if (i_ps_eof) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default:     state_d = ST_IDLE;
                endcase
            end

            if (track) begin
                err_inc = word_err;
                if (i_ps_eof || (word_cnt == FRAME_LEN_VAL)) begin
                    // Close: good only with eof on exactly the last word and clean data.
                    if (bad_now || !i_ps_eof || (word_cnt != FRAME_LEN_VAL)) begin
                        bad_inc = bad_inc + 2'd1;
                    end else begin
                        good_inc = 1'b1;
                    end
                    state_d = i_ps_eof ? ST_IDLE : ST_DROP;
                end else begin
                    state_d     = ST_IN_FRAME;
                    idx_d       = word_cnt;
                    frame_bad_d = bad_now;
                end
            end
        end

        // After a clear the next frame reseeds the sequence.
        if (i_clr) begin
            seeded_d = 1'b0;
        end

        done_d   = good_inc | (bad_inc != 2'd0);
        sticky_d = i_clr ? 1'b0
                         : (sticky_q | err_inc | (bad_inc != 2'd0) | (lost_amt != 32'd0));
    end

    // State and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            seq_q       <= '0;
            exp_seq_q   <= '0;
            seeded_q    <= 1'b0;
            frame_bad_q <= 1'b0;
            rdy_q       <= 1'b0;
            done_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            exp_seq_q   <= exp_seq_d;
            seeded_q    <= seeded_d;
            frame_bad_q <= frame_bad_d;
            rdy_q       <= ~i_stall;
            done_q      <= done_d;
            sticky_q    <= sticky_d;
        end
    end

    sat_cnt32 u_good_cnt (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (i_clr),
        .inc_en_i  (good_inc),
        .inc_amt_i (32'd1),
        .cnt_o     (o_good_frame_num)
    );

    sat_cnt32 u_bad_cnt (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (i_clr),
        .inc_en_i  (bad_inc != 2'd0),
        .inc_amt_i ({30'd0, bad_inc}),
        .cnt_o     (o_bad_frame_num)
    );

    sat_cnt32 u_lost_cnt (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (i_clr),
        .inc_en_i  (lost_amt != 32'd0),
        .inc_amt_i (lost_amt),
        .cnt_o     (o_lost_frame_num)
    );

    sat_cnt32 u_err_word_cnt (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (i_clr),
        .inc_en_i  (err_inc),
        .inc_amt_i (32'd1),
        .cnt_o     (o_err_word_num)
    );

    assign o_ps_rdy     = rdy_q;
    assign o_frame_done = done_q;
    assign o_err_sticky = sticky_q;

endmodule
`default_nettype wire

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
- Terminal consumer of the receive path; sits directly downstream of frame_eof_regen on the i_clk (vl_tx) domain.
- Accepts the o_ps_* frame stream and checks every frame against the transmit test pattern, including word content, length and frame sequence.
- Maintains saturating statistics counters and a sticky error flag for on-board debug and for testbench pass/fail.
- Drives the ready back to frame_eof_regen and supports a programmable stall to exercise backpressure.

Parameters:
- FRAME_LEN_VAL, 16'd200: expected words per frame, including the last word.
- SEQ_CHECK_EN, 1'b1: enables detection of lost frames through sequence-number gaps.

Ports:
- i_clk  in  1  frame clock (vl_tx clock domain)
- i_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous clear of all counters and the sticky flag
- i_stall  in  1  when 1, o_ps_rdy is forced to 0
- i_ps_val  in  1  word valid
- i_ps_sof  in  1  first word of frame
- i_ps_eof  in  1  last word of frame
- i_ps_be  in  2  empty-byte count on the eof word (0..3 invalid low bytes)
- i_ps_data  in  32  payload word
- o_ps_rdy  out  1  ready to frame_eof_regen
- o_good_frame_num  out  32  frames with correct length, data and framing
- o_bad_frame_num  out  32  frames with any data, length or framing error
- o_lost_frame_num  out  32  frames missing according to sequence gaps
- o_err_word_num  out  32  individual mismatched words
- o_err_sticky  out  1  set on first error of any kind; cleared only by reset or i_clr
- o_frame_done  out  1  one-cycle pulse after each frame is closed, good or bad

Behaviour:
- Reset: all counters 0, o_err_sticky 0, o_frame_done 0, o_ps_rdy 0, state IDLE.
- o_ps_rdy is registered and equals ~i_stall one cycle later. A word transfers only when i_ps_val && o_ps_rdy.
- Pattern definition: word k (k = 0..FRAME_LEN_VAL-1) of frame number s is {s[15:0], k[15:0]}.
- Sequence tracking: the first frame after reset or i_clr seeds the expected sequence number from its word 0; no gap is counted for that frame.
- State machine:
  - IDLE:
    - Transfer with sof: enter IN_FRAME, word index = 1, capture s from data[31:16].
    - If SEQ_CHECK_EN and the sequence is seeded: o_lost_frame_num += (s - exp_seq) mod 2^16 when nonzero.
    - exp_seq = s + 1.
    - If sof and eof arrive on the same word, the frame is closed immediately.
    - Transfer without sof: o_err_word_num += 1, stay in IDLE (orphan word, no frame counted).
  - IN_FRAME:
    - Compare data to the expected pattern on every transferred word; on mismatch o_err_word_num += 1 and mark the frame bad.
    - sof mid-frame: close the current frame as bad, then open the new frame on the same word.
    - eof: the frame is bad if the word count != FRAME_LEN_VAL. On the eof word only, the low i_ps_be bytes are excluded from comparison.
    - Index overflow: if the word index reaches FRAME_LEN_VAL without eof, mark the frame bad and enter DROP.
  - DROP: discard words until eof (go to IDLE) or sof (open a new frame). No per-word compare in DROP.
- Frame close:
  - Increments o_good_frame_num or o_bad_frame_num on the cycle after the closing transfer.
  - o_frame_done pulses in that same cycle.
- Counters:
  - 32-bit and saturating at 32'hFFFFFFFF.
  - The lost-frame counter adds the full gap with saturation.
  - Sequence arithmetic is mod 2^16: a wrap from 16'hFFFF to 16'h0000 is not a gap.
- i_clr has priority over same-cycle increments; the state machine keeps running and only counters and sticky are cleared.
- Asynchronous reset mid-frame returns to IDLE; the partial frame is not counted.
- o_err_sticky sets on any o_err_word_num, bad-frame or lost-frame increment.

Decomposition:
- Shared package vlc_frame_pkg:
  - FRAME_LEN_VAL default.
  - Pattern-word construction function.
  - State encodings IDLE/IN_FRAME/DROP.
- One sub-module, sat_cnt32: a saturating 32-bit counter with clear, increment enable and increment amount. It is instantiated four times.

Test Plan:
- Three back-to-back correct frames, seq 5,6,7, 200 words each, be=0 -> good=3, bad=0, lost=0, err_word=0, sticky=0, three o_frame_done pulses.
- Frame seq 10 with word 50 corrupted to 0 -> err_word=1, bad=1, good=0, sticky=1.
- Frame seq 3 followed by frame seq 6 -> lost=2. Frames seq 16'hFFFF then 16'h0000 -> lost unchanged.
- Frame with eof at word 150 -> bad=1. Frame with no eof, 210 words, then a new sof frame -> first frame bad=1, second frame good=1.
- i_stall toggled every 7 cycles during a 200-word frame with i_ps_val held -> o_ps_rdy follows with 1-cycle lag, no words lost, good=1.
- i_clr pulsed during the same cycle as a frame close -> all counters read 0 afterwards and sticky=0. i_rst_n dropped mid-frame -> all outputs return to reset values immediately.
